// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Free-running VGA timing generator with four test patterns and a slow
//   palette rotation. The x/y raster counters drive the sync outputs and a
//   pixel colour function. All outputs are registered, so the values seen in
//   cycle t belong to the (x,y) position of cycle t-1.
//
//   Optional feature (compile-time macro VGA_SCROLL_EN): a per-frame
//   horizontal scroll offset applied to patterns 1-3.
//
// Ports
//   clk         pixel clock
//   rst_n       synchronous active-low reset
//   ena         pixel enable; rgb is forced to 0 while low (timing keeps running)
//   mode[1:0]   pattern select: 0 quadrants, 1 checker, 2 bars, 3 gradient
//               (sampled only at the first pixel of a frame)
//   pause       holds the frame counter, palette rotation and scroll offset
//   hsync       active-low horizontal sync
//   vsync       active-low vertical sync
//   rgb[5:0]    colour {R[1:0],G[1:0],B[1:0]}
//   frame_start one-cycle pulse aligned with the output of pixel (0,0)
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int TILE_LOG2  = 6,
    parameter int ROT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] mode,
    input  logic       pause,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW    = $clog2(H_TOT);
    localparam int YW    = $clog2(V_TOT);
    localparam int FW    = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;

    // Thresholds are one bit wider than the counters so that a bound equal
    // to the total (zero back porch) still fits.
    localparam logic [XW:0] X_LAST   = (XW+1)'(H_TOT - 1);
    localparam logic [XW:0] X_ACT    = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] X_HALF   = (XW+1)'(H_ACTIVE / 2);
    localparam logic [XW:0] X_SYNC_S = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] X_SYNC_E = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0] Y_LAST   = (YW+1)'(V_TOT - 1);
    localparam logic [YW:0] Y_ACT    = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] Y_HALF   = (YW+1)'(V_ACTIVE / 2);
    localparam logic [YW:0] Y_SYNC_S = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] Y_SYNC_E = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [FW-1:0] FC_LAST = FW'(ROT_FRAMES - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW:0]   xz;
    logic [YW:0]   yz;
    logic          at_origin;

    logic [FW-1:0] fc, fc_nxt;
    logic [1:0]    rot, rot_nxt;
    logic [1:0]    mode_q, mode_nxt;

    logic [XW-1:0] x_eff;
    logic [1:0]    x_tile, y_tile;
    logic [1:0]    idx;
    logic [5:0]    rgb_px;
    logic          hs_px, vs_px, active;

    assign xz        = {1'b0, x};
    assign yz        = {1'b0, y};
    assign at_origin = (x == '0) && (y == '0);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (xz == X_LAST) begin
            x <= '0;
            y <= (yz == Y_LAST) ? '0 : y + YW'(1);
        end else begin
            x <= x + XW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-frame state: mode latch, frame counter, rotation.
    // The *_nxt values are also what the pixel path uses, so pixel (0,0)
    // already sees the values that hold for the rest of its frame.
    // ------------------------------------------------------------------
    always_comb begin
        fc_nxt   = fc;
        rot_nxt  = rot;
        mode_nxt = mode_q;
        if (at_origin) begin
            mode_nxt = mode;
            if (!pause) begin
                if (fc == FC_LAST) begin
                    fc_nxt  = '0;
                    rot_nxt = rot + 2'd1;
                end else begin
                    fc_nxt = fc + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fc     <= '0;
            rot    <= '0;
            mode_q <= '0;
        end else begin
            fc     <= fc_nxt;
            rot    <= rot_nxt;
            mode_q <= mode_nxt;
        end
    end

`ifdef VGA_SCROLL_EN
    logic [XW-1:0] scroll, scroll_nxt;

    always_comb begin
        scroll_nxt = scroll;
        if (at_origin && !pause) begin
            scroll_nxt = scroll + XW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scroll <= '0;
        end else begin
            scroll <= scroll_nxt;
        end
    end

    // Sum cannot overflow XW+1 bits; wrap within the visible width.
    assign x_eff = XW'(({1'b0, x} + {1'b0, scroll_nxt}) % X_ACT);
`else
    assign x_eff = x;
`endif

    // ------------------------------------------------------------------
    // Pixel colour and sync for the current (x,y)
    // ------------------------------------------------------------------
    function automatic logic [5:0] palette(input logic [1:0] i);
        logic [5:0] c;
        case (i)
            2'd0:    c = 6'b001100;
            2'd1:    c = 6'b111100;
            2'd2:    c = 6'b110000;
            default: c = 6'b000011;
        endcase
        return c;
    endfunction

    assign x_tile = 2'(x_eff >> TILE_LOG2);
    assign y_tile = 2'(y >> TILE_LOG2);
    assign active = (xz < X_ACT) && (yz < Y_ACT);
    assign hs_px  = !((xz >= X_SYNC_S) && (xz < X_SYNC_E));
    assign vs_px  = !((yz >= Y_SYNC_S) && (yz < Y_SYNC_E));

    always_comb begin
        idx    = 2'd0;
        rgb_px = 6'd0;
        case (mode_nxt)
            2'd0:    idx = {yz >= Y_HALF, xz >= X_HALF} + rot_nxt;
            2'd1:    idx = {x_tile[0] ^ y_tile[0], 1'b0} + rot_nxt;
            2'd2:    idx = x_tile + rot_nxt;
            default: idx = 2'd0;
        endcase
        if (mode_nxt == 2'd3) begin
            rgb_px = {x_tile, y_tile, rot_nxt};
        end else begin
            rgb_px = palette(idx);
        end
        if (!active || !ena) begin
            rgb_px = 6'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= 6'd0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_px;
            vsync       <= vs_px;
            rgb         <= rgb_px;
            frame_start <= at_origin;
        end
    end

endmodule
